// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter driving a byte-wide, 4-phase handshaked
// external bus: address low, address high, then data.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_read,
    input  logic        r0_write,
    input  logic [15:0] r0_addr,
    input  logic [7:0]  r0_wdata,
    output logic        r0_done,
    input  logic        r1_read,
    input  logic        r1_write,
    input  logic [15:0] r1_addr,
    input  logic [7:0]  r1_wdata,
    output logic        r1_done,
    output logic [7:0]  rdata,
    output logic [1:0]  gnt,
    input  logic        hs_in,
    output logic        hs_out,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    output logic        rd_out,
    output logic        wr_out
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        DATA,
        DONE
    } state_t;

    typedef enum logic {
        WAIT_LOW,
        ARMED
    } hs_state_t;

    state_t    state, state_nx;
    hs_state_t hs_st, hs_nx;

    logic        hs_m, hs_s;
    logic        ptr, ptr_nx;
    logic [1:0]  gnt_nx;
    logic [1:0]  owner, owner_nx;
    logic [15:0] addr_q, addr_nx;
    logic [7:0]  wdata_q, wdata_nx;
    logic        wr_q, wr_nx;
    logic [7:0]  rdata_nx;
    logic        pend0, pend1, win, fire, in_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_m <= 1'b0;
            hs_s <= 1'b0;
        end else begin
            hs_m <= hs_in;
            hs_s <= hs_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hs_st   <= WAIT_LOW;
            ptr     <= 1'b0;
            gnt     <= 2'b00;
            owner   <= 2'b00;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            state   <= state_nx;
            hs_st   <= hs_nx;
            ptr     <= ptr_nx;
            gnt     <= gnt_nx;
            owner   <= owner_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            wr_q    <= wr_nx;
            rdata   <= rdata_nx;
        end
    end

    assign pend0 = r0_read | r0_write;
    assign pend1 = r1_read | r1_write;
    assign fire  = (hs_st == ARMED) && hs_s;

    always_comb begin
        state_nx = state;
        hs_nx    = hs_st;
        ptr_nx   = ptr;
        gnt_nx   = gnt;
        owner_nx = owner;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        wr_nx    = wr_q;
        rdata_nx = rdata;
        win      = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    // Tie goes to the pointer; a lone requester always wins
                    win      = (pend0 && pend1) ? ptr : pend1;
                    gnt_nx   = win ? 2'b10 : 2'b01;
                    owner_nx = win ? 2'b10 : 2'b01;
                    ptr_nx   = ~win;
                    addr_nx  = win ? r1_addr : r0_addr;
                    wdata_nx = win ? r1_wdata : r0_wdata;
                    wr_nx    = win ? r1_write : r0_write;
                    state_nx = ADDR_LO;
                end
            end
            ADDR_LO, ADDR_HI, DATA: begin
                if (hs_st == WAIT_LOW && !hs_s) begin
                    hs_nx = ARMED;
                end
                if (fire) begin
                    hs_nx = WAIT_LOW;
                    if (state == ADDR_LO) begin
                        state_nx = ADDR_HI;
                    end else if (state == ADDR_HI) begin
                        state_nx = DATA;
                    end else begin
                        if (!wr_q) begin
                            rdata_nx = bus_in;
                        end
                        // gnt drops here so it never overlaps a done pulse
                        gnt_nx   = 2'b00;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                owner_nx = 2'b00;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                hs_nx    = WAIT_LOW;
            end
        endcase
    end

    assign in_phase = (state == ADDR_LO) || (state == ADDR_HI) ||
                      (state == DATA);

    always_comb begin
        bus_out = wdata_q;
        bus_oe  = 8'h00;
        unique case (state)
            ADDR_LO: begin
                bus_out = addr_q[7:0];
                bus_oe  = 8'hFF;
            end
            ADDR_HI: begin
                bus_out = addr_q[15:8];
                bus_oe  = 8'hFF;
            end
            DATA: begin
                bus_oe = wr_q ? 8'hFF : 8'h00;
            end
            default: begin
                bus_oe = 8'h00;
            end
        endcase
    end

    assign hs_out  = (hs_st == ARMED);
    assign rd_out  = in_phase && !wr_q;
    assign wr_out  = in_phase && wr_q;
    assign r0_done = (state == DONE) && owner[0];
    assign r1_done = (state == DONE) && owner[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter with a handshake responder
// and a transaction-level round-robin reference model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_read, r0_write, r1_read, r1_write;
    logic [15:0] r0_addr, r1_addr;
    logic [7:0]  r0_wdata, r1_wdata;
    logic        r0_done, r1_done;
    logic [7:0]  rdata;
    logic [1:0]  gnt;
    logic        hs_in, hs_out;
    logic [7:0]  bus_in, bus_out, bus_oe;
    logic        rd_out, wr_out;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_read(r0_read), .r0_write(r0_write),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_done(r0_done),
        .r1_read(r1_read), .r1_write(r1_write),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_done(r1_done),
        .rdata(rdata), .gnt(gnt),
        .hs_in(hs_in), .hs_out(hs_out),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .rd_out(rd_out), .wr_out(wr_out)
    );

    typedef struct {
        int          id;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic [7:0] oe;
        logic       rd;
        logic       wr;
    } obs_t;

    exp_t       sbq[$];
    obs_t       obsq[$];
    logic [7:0] rdq[$];

    int n_chk = 0;
    int n_fail = 0;

    int          rem[2];
    logic [15:0] c_addr[2];
    logic [7:0]  c_wd[2];
    int          c_cmd[2];
    int          last_win = 1;
    logic [7:0]  m_rdata = 8'h00;

    int resp_dly = 0;
    int hold_hi = 0;
    int stall_at = -1;
    int phase_cnt = 0;
    int force_rd = -1;
    int cyc = 0;
    int done0_cyc = -100;
    int gnt1_cyc = -100;
    bit mon_en = 1'b0;
    logic [1:0] gnt_prev = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout/underflow expected event", nm);
    endtask

    task automatic setup(input int id, input logic [15:0] a,
                         input logic [7:0] d, input int cmd, input int n);
        c_addr[id] = a;
        c_wd[id]   = d;
        c_cmd[id]  = cmd;
        rem[id]    = n;
    endtask

    task automatic drive(input int id);
        if (id == 0) begin
            r0_addr  = c_addr[0];
            r0_wdata = c_wd[0];
            r0_read  = (c_cmd[0] == 0 || c_cmd[0] == 2);
            r0_write = (c_cmd[0] != 0);
        end else begin
            r1_addr  = c_addr[1];
            r1_wdata = c_wd[1];
            r1_read  = (c_cmd[1] == 0 || c_cmd[1] == 2);
            r1_write = (c_cmd[1] != 0);
        end
    endtask

    task automatic drop(input int id);
        if (id == 0) begin
            r0_read  = 1'b0;
            r0_write = 1'b0;
        end else begin
            r1_read  = 1'b0;
            r1_write = 1'b0;
        end
    endtask

    // Round robin at transaction level: a tie goes to whoever was not
    // served last; held requesters keep competing until served n times.
    task automatic expect_order(input int n0, input int n1);
        int   a0, a1, w;
        exp_t e;
        a0 = n0;
        a1 = n1;
        while (a0 > 0 || a1 > 0) begin
            if (a0 > 0 && a1 > 0) w = (last_win == 0) ? 1 : 0;
            else                  w = (a0 > 0) ? 0 : 1;
            e.id    = w;
            e.wr    = (c_cmd[w] != 0);
            e.addr  = c_addr[w];
            e.wdata = c_wd[w];
            sbq.push_back(e);
            last_win = w;
            if (w == 1) a1--;
            else        a0--;
        end
    endtask

    task automatic wait_quiet();
        int t;
        t = 0;
        while ((rem[0] > 0 || rem[1] > 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_now("txn_timeout");
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 0);
        chk("obs_drained", 32'(obsq.size()), 0);
    endtask

    task automatic wait_phase(input int target);
        int t;
        t = 0;
        while (phase_cnt < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now("phase_timeout");
    endtask

    // Responder: log each phase on hs_out rise, answer, then release
    initial begin
        obs_t       o;
        logic [7:0] v;
        int         t;
        hs_in  = 1'b0;
        bus_in = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && hs_out && !hs_in) begin
                o.b  = bus_out;
                o.oe = bus_oe;
                o.rd = rd_out;
                o.wr = wr_out;
                obsq.push_back(o);
                phase_cnt++;
                if (bus_oe == 8'h00) begin
                    v = (force_rd >= 0) ? force_rd[7:0] : 8'($urandom);
                    force_rd = -1;
                    bus_in = v;
                    rdq.push_back(v);
                end
                while (phase_cnt == stall_at) @(negedge clk);
                repeat (resp_dly) @(negedge clk);
                if (hs_out) begin
                    hs_in = 1'b1;
                    t = 0;
                    while (hs_out && t < 100) begin
                        @(negedge clk);
                        t++;
                    end
                    if (hs_out) fail_now("hs_release");
                    for (int i = 0; i < hold_hi; i++) begin
                        @(negedge clk);
                        chk("hs_hold_low", 32'(hs_out), 0);
                    end
                end
                hs_in = 1'b0;
            end
        end
    end

    // Requesters drop their command in the done cycle once served
    initial begin
        forever begin
            @(negedge clk);
            if (r0_done && rem[0] > 0) begin
                rem[0]--;
                if (rem[0] == 0) drop(0);
            end
            if (r1_done && rem[1] > 0) begin
                rem[1]--;
                if (rem[1] == 0) drop(1);
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on every done
    initial begin
        exp_t       e;
        obs_t       o0, o1, o2;
        logic [7:0] v;
        int         id;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                chk("gnt_onehot", 32'(gnt == 2'b11), 0);
                chk("done_excl", 32'(r0_done && r1_done), 0);
                chk("gnt_done_excl",
                    32'((gnt != 2'b00) && (r0_done || r1_done)), 0);
                if (gnt == 2'b00)
                    chk("idle_outs", {hs_out, rd_out, wr_out, bus_oe}, 0);
                if (r0_done) done0_cyc = cyc;
                if (gnt == 2'b10 && gnt_prev != 2'b10) gnt1_cyc = cyc;
                gnt_prev = gnt;
                if (r0_done || r1_done) begin
                    id = r1_done ? 1 : 0;
                    if (sbq.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = sbq.pop_front();
                        chk("done_id", 32'(id), 32'(e.id));
                        if (obsq.size() < 3) begin
                            fail_now("phase_count");
                            obsq.delete();
                        end else begin
                            o0 = obsq.pop_front();
                            o1 = obsq.pop_front();
                            o2 = obsq.pop_front();
                            chk("addr_lo", 32'(o0.b), 32'(e.addr[7:0]));
                            chk("addr_hi", 32'(o1.b), 32'(e.addr[15:8]));
                            chk("oe_addr", {o0.oe, o1.oe}, 32'h0000FFFF);
                            if (e.wr) begin
                                chk("wdata", 32'(o2.b), 32'(e.wdata));
                                chk("oe_wdata", 32'(o2.oe), 32'hFF);
                            end else begin
                                chk("oe_rdata", 32'(o2.oe), 0);
                            end
                            chk("rd_wr",
                                {o0.rd, o0.wr, o1.rd, o1.wr, o2.rd, o2.wr},
                                e.wr ? 32'b010101 : 32'b101010);
                        end
                        if (!e.wr) begin
                            if (rdq.size() == 0) begin
                                fail_now("rdata_source");
                            end else begin
                                v = rdq.pop_front();
                                m_rdata = v;
                            end
                        end
                        chk("rdata", 32'(rdata), 32'(m_rdata));
                    end
                end
            end
        end
    end

    initial begin
        int n0, n1;
        rst_n = 1'b0;
        drop(0);
        drop(1);
        r0_addr = 16'h0;
        r1_addr = 16'h0;
        r0_wdata = 8'h0;
        r1_wdata = 8'h0;
        rem[0] = 0;
        rem[1] = 0;
        repeat (3) @(negedge clk);
        chk("rst_outs",
            {gnt, hs_out, r0_done, r1_done, rd_out, wr_out, bus_oe, rdata}, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        force_rd = 32'hA5;
        setup(0, 16'h1234, 8'h00, 0, 1);
        expect_order(1, 0);
        drive(0);
        wait_quiet();
        chk("single_read_rdata", 32'(rdata), 32'hA5);

        setup(1, 16'hBEEF, 8'h5A, 1, 1);
        expect_order(0, 1);
        drive(1);
        wait_quiet();
        chk("single_write_rdata", 32'(rdata), 32'hA5);

        setup(0, 16'($urandom), 8'($urandom), 0, 2);
        setup(1, 16'($urandom), 8'($urandom), 2, 1);
        expect_order(2, 1);
        drive(0);
        drive(1);
        wait_quiet();

        n0 = phase_cnt;
        setup(0, 16'($urandom), 8'($urandom), 1, 1);
        expect_order(1, 0);
        drive(0);
        wait_phase(n0 + 2);
        setup(1, 16'($urandom), 8'($urandom), 0, 1);
        expect_order(0, 1);
        drive(1);
        wait_quiet();
        chk("late_gap", 32'(gnt1_cyc - done0_cyc), 2);

        stall_at = phase_cnt + 3;
        setup(1, 16'($urandom), 8'($urandom), 1, 1);
        drive(1);
        wait_phase(stall_at);
        repeat (4) @(negedge clk);
        chk("pre_rst_hs", 32'(hs_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {hs_out, gnt, bus_oe, rd_out, wr_out}, 0);
        drop(1);
        rem[1] = 0;
        last_win = 1;
        m_rdata = 8'h00;
        @(negedge clk);
        stall_at = -1;
        repeat (4) @(negedge clk);
        obsq.delete();
        chk("rst_rdata", 32'(rdata), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        setup(1, 16'($urandom), 8'($urandom), 0, 1);
        expect_order(0, 1);
        drive(1);
        wait_quiet();

        hold_hi = 10;
        setup(0, 16'($urandom), 8'($urandom), 0, 1);
        setup(1, 16'($urandom), 8'($urandom), 1, 1);
        expect_order(1, 1);
        drive(0);
        drive(1);
        wait_quiet();
        hold_hi = 0;

        for (int it = 0; it < 10; it++) begin
            resp_dly = $urandom_range(0, 3);
            hold_hi  = $urandom_range(0, 3);
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 == 0 && n1 == 0) n0 = 1;
            setup(0, 16'($urandom), 8'($urandom), $urandom_range(0, 2), n0);
            setup(1, 16'($urandom), 8'($urandom), $urandom_range(0, 2), n1);
            expect_order(n0, n1);
            if (n0 > 0) drive(0);
            if (n1 > 0) drive(1);
            wait_quiet();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
